phj_tuple_hasher: RTL

Upstream feeder for the hash-table stage of the partitioned hash join. Accepts one tuple stream carrying the build relation followed by the probe relation. For each tuple it computes a 32-bit murmur3-fmix32 hash of the join key, which is bits [31:0] of the tuple. It tags each tuple with its phase (build or probe), a probe serial number and a per-phase last flag, then presents the result on a pipelined valid/ready output that the hash table's build/probe inputs consume.

---
 rtl/phj_tuple_hasher_if.sv | 28 ++
 rtl/phj_tuple_hasher.sv | 112 +++++++++++
 2 files changed

// File: rtl/phj_tuple_hasher_if.sv
// Tuple stream bundle for the hash-join hasher: input tuple channel, tagged output
// channel and the end-of-join done flag. The DUT uses the slave modport; the feeder/sink uses master.
interface phj_tuple_hasher_if #(
  parameter int SERIAL_WIDTH = 64
);
  logic                    s_valid;
  logic                    s_ready;
  logic [63:0]             s_data;
  logic                    s_last;
  logic                    m_valid;
  logic                    m_ready;
  logic [63:0]             m_data;
  logic [31:0]             m_hash;
  logic                    m_last;
  logic                    m_phase;
  logic [SERIAL_WIDTH-1:0] m_serialnum;
  logic                    done;

  modport master (
    output s_valid, s_data, s_last, m_ready,
    input  s_ready, m_valid, m_data, m_hash, m_last, m_phase, m_serialnum, done
  );

  modport slave (
    input  s_valid, s_data, s_last, m_ready,
    output s_ready, m_valid, m_data, m_hash, m_last, m_phase, m_serialnum, done
  );
endinterface

// File: rtl/phj_tuple_hasher.sv
// Partitioned-hash-join tuple hasher: 3-stage murmur3 fmix32 pipeline with build/probe tagging.
// Optional macro PHJ_HASHER_DROP_ZERO_KEY_EN swallows key-0 tuples (last flag kept on a zero bubble).
module phj_tuple_hasher #(
  parameter logic [31:0] SEED         = 32'h0000_0000,
  parameter int          SERIAL_WIDTH = 64
) (
  input  logic                clk,
  input  logic                resetn,
  phj_tuple_hasher_if.slave   bus
);

  localparam int          STAGES = 3;
  localparam logic [31:0] C1     = 32'h85EB_CA6B;
  localparam logic [31:0] C2     = 32'hC2B2_AE35;

  typedef enum logic [1:0] {ST_BUILD, ST_PROBE, ST_DONE} state_e;

  typedef struct packed {
    logic [63:0]             data;
    logic [31:0]             hash;
    logic                    last;
    logic                    phase;
    logic [SERIAL_WIDTH-1:0] serial;
  } stage_t;

  state_e                  state_q, state_d;
  logic [SERIAL_WIDTH-1:0] cnt_q, cnt_d;
  logic [STAGES:1]         vld_pipe_q, vld_pipe_d;
  stage_t                  st1_q, st1_d, st2_q, st2_d, st3_q, st3_d;
  logic                    done_q, done_d;

  logic        adv, accept, drop, in_vld, in_probe;
  logic [31:0] key_x, mix1, mix2;

  always_comb begin
    adv      = ~vld_pipe_q[STAGES] | bus.m_ready;
    accept   = bus.s_valid & adv & (state_q != ST_DONE);
    in_probe = (state_q == ST_PROBE);
    key_x    = bus.s_data[31:0] ^ SEED;
`ifdef PHJ_HASHER_DROP_ZERO_KEY_EN
    drop     = (bus.s_data[31:0] == 32'h0);
`else
    drop     = 1'b0;
`endif
    // A dropped tuple only occupies a slot if it must carry the end-of-phase flag.
    in_vld   = accept & (~drop | bus.s_last);
    mix1     = st1_q.hash ^ (st1_q.hash >> 13);
    mix2     = st2_q.hash;

    vld_pipe_d = vld_pipe_q;
    st1_d      = st1_q;
    st2_d      = st2_q;
    st3_d      = st3_q;
    state_d    = state_q;
    cnt_d      = cnt_q;
    done_d     = done_q | (vld_pipe_q[STAGES] & bus.m_ready & st3_q.last & st3_q.phase);

    if (adv) begin
      vld_pipe_d   = {vld_pipe_q[STAGES-1:1], in_vld};
      st1_d.data   = drop ? 64'h0 : bus.s_data;
      st1_d.hash   = drop ? 32'h0 : (key_x ^ (key_x >> 16)) * C1;
      st1_d.last   = bus.s_last;
      st1_d.phase  = in_probe;
      st1_d.serial = (in_probe & ~drop) ? cnt_q : '0;
      st2_d        = st1_q;
      st2_d.hash   = mix1 * C2;
      st3_d        = st2_q;
      st3_d.hash   = mix2 ^ (mix2 >> 16);
    end

    if (accept) begin
      case (state_q)
        ST_BUILD: if (bus.s_last) state_d = ST_PROBE;
        ST_PROBE: begin
          if (!drop) cnt_d = cnt_q + SERIAL_WIDTH'(1);
          if (bus.s_last) state_d = ST_DONE;
        end
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= ST_BUILD;
      cnt_q      <= '0;
      vld_pipe_q <= '0;
      st1_q      <= '0;
      st2_q      <= '0;
      st3_q      <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      vld_pipe_q <= vld_pipe_d;
      st1_q      <= st1_d;
      st2_q      <= st2_d;
      st3_q      <= st3_d;
      done_q     <= done_d;
    end
  end

  assign bus.s_ready     = adv & (state_q != ST_DONE);
  assign bus.m_valid     = vld_pipe_q[STAGES];
  assign bus.m_data      = st3_q.data;
  assign bus.m_hash      = st3_q.hash;
  assign bus.m_last      = st3_q.last;
  assign bus.m_phase     = st3_q.phase;
  assign bus.m_serialnum = st3_q.serial;
  assign bus.done        = done_q;

endmodule
